button_event_scheduler: RTL and testbench

- Sits downstream of per-button debouncers and takes NUM_BTN already-debounced button levels.
- Runs a per-button press/hold FSM that produces press, release, long-press and (optionally) auto-repeat events.
- Arbitrates pending events round-robin into one valid/ready event stream consumed by the UI/control logic.
- Shares one tick prescaler across all buttons.

---
 rtl/button_event_scheduler_pkg.sv | 24 ++
 rtl/button_event_scheduler_if.sv | 26 ++
 rtl/button_event_scheduler_hold_fsm.sv | 132 +++++++++++++
 rtl/button_event_scheduler.sv | 116 +++++++++++
 tb/tb_button_event_scheduler.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/button_event_scheduler_pkg.sv
// Shared event codes, per-button state encoding and width helper for the
// button event scheduler.
package button_event_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } btn_state_e;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// Event stream seen by the UI/control logic, plus per-button FSM state for
// observation. The scheduler drives the master side.
interface button_event_scheduler_if #(
  parameter int NUM_BTN = 4,
  parameter int IDW     = 2
);
  // Handshake: an event transfers on a clock edge where evt_valid_o and
  // evt_ready_i are both 1. While evt_valid_o=1 and evt_ready_i=0, valid, id
  // and type hold stable; valid only falls after a transfer.
  logic                   evt_valid_o;
  logic                   evt_ready_i;
  logic [IDW-1:0]         evt_id_o;
  logic [1:0]             evt_type_o;
  logic                   drop_o;
  logic [2*NUM_BTN-1:0]   dbg_state_o;

  modport master (
    output evt_valid_o, evt_id_o, evt_type_o, drop_o, dbg_state_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o, evt_id_o, evt_type_o, drop_o, dbg_state_o,
    output evt_ready_i
  );
endinterface

// File: rtl/button_event_scheduler_hold_fsm.sv
// One button: edge detect, press/hold FSM, hold counter and pending slot.
// Auto-repeat in HELD is enabled by BUTTON_EVENT_SCHEDULER_AUTO_REPEAT_EN.
module btn_hold_fsm
  import button_event_pkg::*;
#(
  parameter int   LONG_TICKS   = 1000,
  parameter int   REPEAT_TICKS = 200,
  parameter logic ACTIVE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn,
  input  logic       i_tick,
  input  logic       i_grant,
  output logic       o_pend_v,
  output logic [1:0] o_pend_type,
  output logic       o_drop,
  output btn_state_e o_state
);

  localparam int CNTW = clog2_min1((LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS);
  localparam logic [CNTW-1:0] LONG_LAST   = CNTW'(LONG_TICKS - 1);
  localparam logic [CNTW-1:0] REPEAT_LAST = CNTW'(REPEAT_TICKS - 1);

  logic            r_btn_q;
  btn_state_e      r_state;
  btn_state_e      w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_press;
  logic            w_release;
  logic            w_emit;
  logic [1:0]      w_emit_type;
  logic            r_pend_v;
  logic [1:0]      r_pend_type;
  logic            r_drop;

  assign w_press   = (i_btn == ACTIVE_LEVEL) && (r_btn_q != ACTIVE_LEVEL);
  assign w_release = (i_btn != ACTIVE_LEVEL) && (r_btn_q == ACTIVE_LEVEL);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_emit_type = EVT_PRESS;
    case (r_state)
      IDLE: begin
        if (w_press) begin
          w_emit      = 1'b1;
          w_emit_type = EVT_PRESS;
          w_cnt_nxt   = '0;
          w_state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        // Release wins over a tick landing in the same cycle.
        if (w_release) begin
          w_emit      = 1'b1;
          w_emit_type = EVT_RELEASE;
          w_state_nxt = IDLE;
        end else if (i_tick) begin
          if (r_cnt == LONG_LAST) begin
            w_emit      = 1'b1;
            w_emit_type = EVT_LONG;
            w_cnt_nxt   = '0;
            w_state_nxt = HELD;
          end else begin
            w_cnt_nxt = r_cnt + CNTW'(1);
          end
        end
      end
      HELD: begin
        if (w_release) begin
          w_emit      = 1'b1;
          w_emit_type = EVT_RELEASE;
          w_state_nxt = IDLE;
        end
`ifdef BUTTON_EVENT_SCHEDULER_AUTO_REPEAT_EN
        else if (i_tick) begin
          if (r_cnt == REPEAT_LAST) begin
            w_emit      = 1'b1;
            w_emit_type = EVT_REPEAT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNTW'(1);
          end
        end
`else
        else if (i_tick && (r_cnt == REPEAT_LAST)) begin
          w_cnt_nxt = r_cnt;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q <= ~ACTIVE_LEVEL;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_btn_q <= i_btn;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A new event always takes the slot; losing an ungranted one is a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_v    <= 1'b0;
      r_pend_type <= EVT_PRESS;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= w_emit && r_pend_v && !i_grant;
      if (w_emit) begin
        r_pend_v    <= 1'b1;
        r_pend_type <= w_emit_type;
      end else if (i_grant) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  assign o_pend_v    = r_pend_v;
  assign o_pend_type = r_pend_type;
  assign o_drop      = r_drop;
  assign o_state     = r_state;

endmodule

// File: rtl/button_event_scheduler.sv
// Button event scheduler: shared tick prescaler, NUM_BTN hold FSMs and a
// round-robin arbiter onto one valid/ready stream. Auto-repeat is enabled by
// defining BUTTON_EVENT_SCHEDULER_AUTO_REPEAT_EN.
module button_event_scheduler
  import button_event_pkg::*;
#(
  parameter int   NUM_BTN      = 4,
  parameter int   CLOCK_FREQ   = 100000000,
  parameter int   TICK_HZ      = 1000,
  parameter int   LONG_TICKS   = 1000,
  parameter int   REPEAT_TICKS = 200,
  parameter logic ACTIVE_LEVEL = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_BTN-1:0]        btn_i,
  button_event_scheduler_if.master  evt_if
);

  localparam int IDW   = clog2_min1(NUM_BTN);
  localparam int PRESC = CLOCK_FREQ / TICK_HZ;
  localparam int PW    = clog2_min1(PRESC);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESC - 1);
  localparam logic [IDW-1:0] ID_LAST    = IDW'(NUM_BTN - 1);

  logic [PW-1:0]        r_presc;
  logic                 w_tick;
  logic [NUM_BTN-1:0]   w_pend_v;
  logic [1:0]           w_pend_type [NUM_BTN];
  logic [NUM_BTN-1:0]   w_drop;
  btn_state_e           w_state [NUM_BTN];
  logic [NUM_BTN-1:0]   w_grant;
  logic [2*NUM_BTN-1:0] w_dbg;
  logic [IDW-1:0]       r_rr;
  logic                 r_valid;
  logic [IDW-1:0]       r_id;
  logic [1:0]           r_type;
  logic                 w_found;
  logic [IDW-1:0]       w_win;
  logic                 w_load;

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_hold_fsm #(
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .ACTIVE_LEVEL(ACTIVE_LEVEL)
    ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_btn      (btn_i[g]),
      .i_tick     (w_tick),
      .i_grant    (w_grant[g]),
      .o_pend_v   (w_pend_v[g]),
      .o_pend_type(w_pend_type[g]),
      .o_drop     (w_drop[g]),
      .o_state    (w_state[g])
    );
  end

  // First pending slot at or after r_rr, wrapping past the last button.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      idx = int'(r_rr) + i;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      if (!w_found && w_pend_v[idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  assign w_load  = !r_valid || evt_if.evt_ready_i;
  assign w_grant = (w_load && w_found) ? (NUM_BTN'(1) << w_win) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_type  <= EVT_PRESS;
      r_rr    <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_id    <= w_win;
        r_type  <= w_pend_type[w_win];
        r_rr    <= (w_win == ID_LAST) ? '0 : w_win + IDW'(1);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_dbg = '0;
    for (int i = 0; i < NUM_BTN; i++) w_dbg[2*i +: 2] = w_state[i];
  end

  assign evt_if.evt_valid_o = r_valid;
  assign evt_if.evt_id_o    = r_id;
  assign evt_if.evt_type_o  = r_type;
  assign evt_if.drop_o      = |w_drop;
  assign evt_if.dbg_state_o = w_dbg;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with a 10-cycle tick,
// LONG_TICKS=3 and REPEAT_TICKS=2.
module tb_button_event_scheduler;
  import button_event_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;
  int         cyc = 0;
  int         n_total = 0;
  int         n_bad = 0;
  int         drop_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int         got_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_event_scheduler_if #(.NUM_BTN(4), .IDW(2)) u_if ();

  button_event_scheduler #(
    .NUM_BTN(4), .CLOCK_FREQ(100), .TICK_HZ(10),
    .LONG_TICKS(3), .REPEAT_TICKS(2), .ACTIVE_LEVEL(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn),
    .evt_if(u_if)
  );

  // Transfer monitor: a transfer is recorded on the cycle valid&&ready is seen.
  always @(negedge clk) begin
    if (rst_n && u_if.evt_valid_o && u_if.evt_ready_i) begin
      got_q.push_back({u_if.evt_id_o, u_if.evt_type_o});
      got_t.push_back(cyc);
    end
    if (rst_n && u_if.drop_o) drop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn = 4'b0000;
    u_if.evt_ready_i = 1'b1;
    step(3);
    rst_n = 1'b1;
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    drop_cnt = 0;
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_evt"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int n;
    int dt;
    // Reset state
    u_if.evt_ready_i = 1'b1;
    step(3);
    check("rst_valid", u_if.evt_valid_o, 0);
    check("rst_id", u_if.evt_id_o, 0);
    check("rst_type", u_if.evt_type_o, 0);
    check("rst_drop", u_if.drop_o, 0);
    check("rst_state", u_if.dbg_state_o, 0);
    rst_n = 1'b1;
    step(100);
    check("idle_nevt", got_q.size(), 0);
    check("idle_valid", u_if.evt_valid_o, 0);

    // Short press on button 2
    do_reset();
    btn[2] = 1'b1; n = cyc;
    step(15);
    btn[2] = 1'b0;
    step(10);
    exp_q.push_back({2'd2, EVT_PRESS});
    exp_q.push_back({2'd2, EVT_RELEASE});
    compare_events("short");
    if (got_t.size() >= 2) begin
      check("short_press_lat", got_t[0] - n, 2);
      check("short_rel_lat", got_t[1] - n, 17);
    end

    // Long hold on button 1
    do_reset();
    btn[1] = 1'b1; n = cyc;
`ifdef BUTTON_EVENT_SCHEDULER_AUTO_REPEAT_EN
    step(80);
`else
    step(60);
`endif
    btn[1] = 1'b0;
    step(10);
    exp_q.push_back({2'd1, EVT_PRESS});
    exp_q.push_back({2'd1, EVT_LONG});
`ifdef BUTTON_EVENT_SCHEDULER_AUTO_REPEAT_EN
    if (got_t.size() >= 2) begin
      for (int k = 1; got_t[1] + 20 * k < n + 82; k++) exp_q.push_back({2'd1, EVT_REPEAT});
      for (int i = 2; i + 1 < got_t.size(); i++)
        check("rep_spacing", got_t[i] - got_t[i-1], 20);
    end
`endif
    exp_q.push_back({2'd1, EVT_RELEASE});
    compare_events("long");
    if (got_t.size() >= 3) begin
      check("long_press_lat", got_t[0] - n, 2);
      dt = got_t[1] - got_t[0];
      check("long_window", (dt >= 20 && dt <= 30), 1);
`ifdef BUTTON_EVENT_SCHEDULER_AUTO_REPEAT_EN
      check("long_rel_lat", got_t[got_t.size()-1] - n, 82);
`else
      check("long_rel_lat", got_t[2] - n, 62);
`endif
    end

    // Round-robin under backpressure
    do_reset();
    u_if.evt_ready_i = 1'b0;
    btn = 4'b1111;
    step(4);
    check("rr_valid", u_if.evt_valid_o, 1);
    check("rr_id", u_if.evt_id_o, 0);
    check("rr_type", u_if.evt_type_o, EVT_PRESS);
    step(3);
    check("rr_hold_valid", u_if.evt_valid_o, 1);
    check("rr_hold_id", u_if.evt_id_o, 0);
    u_if.evt_ready_i = 1'b1; n = cyc;
    step(8);
    for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), EVT_PRESS});
    compare_events("rr");
    for (int i = 0; i < got_t.size(); i++) check("rr_cycle", got_t[i] - n, i);
    check("rr_idle", u_if.evt_valid_o, 0);

    // Pending-slot overwrite on button 3 while output is occupied
    do_reset();
    u_if.evt_ready_i = 1'b0;
    btn[0] = 1'b1;
    step(4);
    btn[3] = 1'b1;
    step(3);
    check("ovw_no_drop_yet", drop_cnt, 0);
    btn[3] = 1'b0;
    step(3);
    check("ovw_drop", drop_cnt, 1);
    check("ovw_out_id", u_if.evt_id_o, 0);
    u_if.evt_ready_i = 1'b1;
    step(6);
    exp_q.push_back({2'd0, EVT_PRESS});
    exp_q.push_back({2'd3, EVT_RELEASE});
    compare_events("ovw");

    // Button held across reset produces a press after reset release
    do_reset();
    btn[2] = 1'b1;
    step(2);
    rst_n = 1'b0;
    step(2);
    check("mid_rst_valid", u_if.evt_valid_o, 0);
    got_q.delete(); got_t.delete(); exp_q.delete();
    rst_n = 1'b1; n = cyc;
    step(6);
    exp_q.push_back({2'd2, EVT_PRESS});
    compare_events("held_rst");
    if (got_t.size() >= 1) check("held_rst_lat", got_t[0] - n, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
